// File: rtl/la_capture_core.sv
// Logic-analyser capture core: prescaled sampling into a ring buffer with a
// mask/value trigger, pre-trigger history and a valid/ready readout port.
module la_capture_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int TS_W   = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   _mrst,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_arm,
  input  logic                   i_abort,
  input  logic [DATA_W-1:0]      i_trig_mask,
  input  logic [DATA_W-1:0]      i_trig_value,
  input  logic                   i_trig_edge,
  input  logic [AW-1:0]          i_pre_count,
  input  logic [31:0]            i_prescaler,
  output logic                   o_run,
  output logic                   o_triggered,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [TS_W+DATA_W-1:0] o_rd_data,
  output logic                   o_done
);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_TRIG, POST, READ} state_t;

  state_t                  state;
  logic [AW-1:0]           pre_q, wptr, trig_ptr, rd_ptr, post_left, rd_cnt;
  logic [31:0]             presc_q, pcnt;
  logic [DATA_W-1:0]       mask_q, value_q;
  logic                    edge_q, prev_match;
  logic [TS_W-1:0]         ts;
  logic [TS_W+DATA_W-1:0]  mem [DEPTH];

  logic capturing, strobe, match, trig_hit, wr_en;

  assign capturing = (state == ARMED) || (state == WAIT_TRIG) || (state == POST);
  assign strobe    = capturing && (pcnt == 32'd0);
  assign match     = ((i_data ^ value_q) & mask_q) == '0;
  assign trig_hit  = (state == WAIT_TRIG) && strobe && match && (!edge_q || !prev_match);
  // POST with nothing left to write only waits one clock to hand over to READ
  assign wr_en     = strobe && ((state != POST) || (post_left != '0));
  assign o_run     = capturing;

  always_ff @(posedge i_clk)
    if (wr_en) mem[wptr] <= {ts, i_data};

  always_ff @(posedge i_clk) begin
    if (!_mrst) begin
      state       <= IDLE;
      pre_q       <= '0;
      wptr        <= '0;
      trig_ptr    <= '0;
      rd_ptr      <= '0;
      post_left   <= '0;
      rd_cnt      <= '0;
      presc_q     <= '0;
      pcnt        <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= 1'b0;
      prev_match  <= 1'b0;
      ts          <= '0;
      o_triggered <= 1'b0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_done      <= 1'b0;
    end else if (i_abort) begin
      state       <= IDLE;
      o_triggered <= 1'b0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (capturing) pcnt <= (pcnt == presc_q) ? 32'd0 : pcnt + 32'd1;
      if (wr_en) begin
        wptr       <= wptr + AW'(1);
        ts         <= ts + TS_W'(1);
        prev_match <= match;
      end
      case (state)
        IDLE: if (i_arm) begin
          pre_q      <= i_pre_count;
          presc_q    <= i_prescaler;
          mask_q     <= i_trig_mask;
          value_q    <= i_trig_value;
          edge_q     <= i_trig_edge;
          ts         <= '0;
          pcnt       <= '0;
          wptr       <= '0;
          prev_match <= 1'b0;
          state      <= (i_pre_count == '0) ? WAIT_TRIG : ARMED;
        end
        ARMED: if (strobe && (wptr + AW'(1) == pre_q)) state <= WAIT_TRIG;
        WAIT_TRIG: if (trig_hit) begin
          trig_ptr    <= wptr;
          post_left   <= AW'(DEPTH - 1) - pre_q;
          o_triggered <= 1'b1;
          state       <= POST;
        end
        POST: begin
          if (post_left == '0) begin
            state  <= READ;
            rd_ptr <= trig_ptr - pre_q;
            rd_cnt <= '0;
          end else if (strobe) begin
            post_left <= post_left - AW'(1);
          end
        end
        READ: begin
          // first clock in READ prefetches the oldest word
          if (!o_rd_valid) begin
            o_rd_data  <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + AW'(1);
            o_rd_valid <= 1'b1;
          end else if (i_rd_ready) begin
            if (rd_cnt == AW'(DEPTH - 1)) begin
              o_rd_valid  <= 1'b0;
              o_rd_data   <= '0;
              o_done      <= 1'b1;
              o_triggered <= 1'b0;
              state       <= IDLE;
            end else begin
              o_rd_data <= mem[rd_ptr];
              rd_ptr    <= rd_ptr + AW'(1);
              rd_cnt    <= rd_cnt + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/la_capture_core.md
LA_CAPTURE_CORE -- requirements
Module: la_capture_core

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the sample width in bits.
REQ-002 Parameter DEPTH, default 32, power of two >= 4, SHALL set the capture buffer depth in samples; AW = log2(DEPTH).
REQ-003 Parameter TS_W, default 16, SHALL set the timestamp width in bits.
REQ-004 i_clk  in  1  SHALL be the single clock; all logic is clocked on its rising edge.
REQ-005 _mrst  in  1  SHALL be the synchronous, active-low reset.
REQ-006 i_data  in  DATA_W  SHALL be the probed input channels.
REQ-007 i_arm  in  1  SHALL be the single-cycle capture start request.
REQ-008 i_abort  in  1  SHALL be the single-cycle capture cancel request.
REQ-009 i_trig_mask / i_trig_value  in  DATA_W each  SHALL select the trigger bits and their required values.
REQ-010 i_trig_edge  in  1  SHALL select level match (0) or match-entry edge (1).
REQ-011 i_pre_count  in  AW  SHALL give the number of pre-trigger samples kept.
REQ-012 i_prescaler  in  32  SHALL give the sample period minus one, in clocks.
REQ-013 o_run  out  1  SHALL be high in ARMED, WAIT_TRIG and POST.
REQ-014 o_triggered  out  1  SHALL be high from the trigger sample until return to IDLE.
REQ-015 o_rd_valid / i_rd_ready  out/in  1 each  SHALL form the readout handshake.
REQ-016 o_rd_data  out  TS_W+DATA_W  SHALL carry {timestamp, sample} of the current readout word.
REQ-017 o_done  out  1  SHALL pulse for one clock on the final readout transfer.

Function
REQ-018 States SHALL be IDLE, ARMED, WAIT_TRIG, POST and READ.
REQ-019 In IDLE, i_arm SHALL latch i_pre_count, i_prescaler and the trigger configuration, clear the timestamp, the prescaler counter and the write pointer, and enter ARMED; when latched pre_count = 0 it SHALL enter WAIT_TRIG directly.
REQ-020 i_arm outside IDLE SHALL be ignored.
REQ-021 The sample strobe SHALL fire on the first clock after arming and then every prescaler+1 clocks; prescaler 0 SHALL strobe every clock.
REQ-022 The timestamp SHALL increment by one per strobe, modulo 2^TS_W, and SHALL be stored with every sample.
REQ-023 Each strobe in ARMED, WAIT_TRIG or POST SHALL write {ts, i_data} at the write pointer, and the pointer SHALL then advance modulo DEPTH (ring buffer).
REQ-024 ARMED SHALL move to WAIT_TRIG once pre_count samples are stored; trigger matches during ARMED SHALL be ignored.
REQ-025 A match SHALL be ((i_data ^ value) & mask) == 0; mask = 0 SHALL always match.
REQ-026 Edge mode SHALL trigger only on a strobe that matches when the previous strobe's sample did not; the previous-match flag SHALL clear on arm.
REQ-027 On a triggering strobe, that sample SHALL be written as the first post-trigger sample, its address SHALL be latched as trig_ptr, and the state SHALL become POST.
REQ-028 POST SHALL write exactly DEPTH - pre_count samples in total, trigger sample included, then enter READ.
REQ-029 READ SHALL output DEPTH words in chronological order, starting at (trig_ptr - pre_count) mod DEPTH.
REQ-030 o_rd_valid SHALL rise exactly 2 clocks after the final POST write.
REQ-031 o_rd_data SHALL hold stable while o_rd_valid && !i_rd_ready.
REQ-032 A transfer SHALL occur on a clock where o_rd_valid && i_rd_ready; back-to-back transfers SHALL be sustained at one word per clock.
REQ-033 After the DEPTH-th transfer, o_done SHALL pulse, o_rd_valid SHALL drop, and the state SHALL become IDLE on the next clock.
REQ-034 i_abort in any state SHALL force IDLE on the next clock, deassert o_run, o_triggered and o_rd_valid, and suppress o_done; abort SHALL take priority over arm, trigger and transfer.

Reset
REQ-035 With _mrst low at a clock edge, the state SHALL become IDLE and every output, the pointers, the timestamp, the prescaler counter and the previous-match flag SHALL be 0; buffer contents need not be cleared.
REQ-036 Reset asserted mid-capture or mid-readout SHALL behave identically to REQ-035, with no further transfers and no o_done pulse.

Verification
REQ-037 DEPTH=8, pre=3, prescaler=0, level mask=0xFF value=0x05, i_data counting from 0 each clock -> READ yields samples 2,3,4,5,6,7,8,9 with consecutive timestamps; o_done pulses on the 8th transfer.
REQ-038 Edge mode, value 0x01, mask 0x01, data held at 0x01 from arm -> no trigger until data goes 0x00 then 0x01; the trigger sample is at index pre_count of the readout.
REQ-039 prescaler=3 -> strobes exactly 4 clocks apart; timestamps step by 1 per stored sample.
REQ-040 pre=0 -> ARMED is skipped, and the first readout word is the trigger sample.
REQ-041 i_rd_ready toggled randomly during READ -> data stable while stalled, no word lost or duplicated, and exactly 8 transfers.
REQ-042 i_abort in POST, and _mrst low in READ -> IDLE on the next clock with all outputs 0; a new i_arm is then accepted.
